// File: rtl/call_request_latch.sv
// ---------------------------------------------------------------------------
// call_request_latch
//
// Purpose: latches elevator call requests from three floors of raw cabin and
// hall buttons. Each button is synchronised, optionally debounced, edge
// detected and latched into a pending bit. A pending bit is cleared when the
// car serves that floor, i.e. doorOpen=1 while display shows the floor.
//
// Configuration macro: CALL_DEBOUNCE_EN
//   defined   : each synchronised button goes through a saturating counter
//               filter of DEBOUNCE_CYCLES consecutive cycles.
//   undefined : the filtered level is the synchroniser output; no counters.
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   f_btn[2:0] in   raw cabin buttons, bit n = floor n+1
//   u_btn[2:0] in   raw up-hall buttons, bit2 does not exist
//   d_btn[2:0] in   raw down-hall buttons, bit0 does not exist
//   display    in   current floor 1..3, 0 = no floor
//   doorOpen   in   high while the displayed floor is being served
//   reg_f      out  pending cabin requests
//   reg_u      out  pending up-hall requests (bit2 always 0)
//   reg_d      out  pending down-hall requests (bit0 always 0)
//   req_any    out  OR of all pending bits
//   new_call   out  one-cycle pulse when any pending bit rises
// ---------------------------------------------------------------------------
module call_request_latch #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] f_btn,
    input  logic [2:0] u_btn,
    input  logic [2:0] d_btn,
    input  logic [1:0] display,
    input  logic       doorOpen,
    output logic [2:0] reg_f,
    output logic [2:0] reg_u,
    output logic [2:0] reg_d,
    output logic       req_any,
    output logic       new_call
);

    // Button vector layout: [2:0] cabin, [5:3] up-hall, [8:6] down-hall.
    // Up floor 3 and down floor 1 do not exist and are forced to 0.
    localparam logic [8:0] REAL_MASK = 9'b110_011_111;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_param
        $error("call_request_latch: DEBOUNCE_CYCLES must be 2..255");
    end

    logic [8:0] sync1_q, sync1_d;
    logic [8:0] sync2_q, sync2_d;
    logic [1:0] valid_q, valid_d;
    logic [8:0] prev_q, prev_d;
    logic [8:0] seen_low_q, seen_low_d;
    logic [8:0] pend_q, pend_d;
    logic       req_any_q, req_any_d;
    logic       new_call_q, new_call_d;

    logic [8:0] btn_s;
    logic [8:0] level;
    logic [8:0] rise;
    logic [8:0] clr_mask;

    assign btn_s = sync2_q & REAL_MASK;

`ifdef CALL_DEBOUNCE_EN
    logic [8:0]      level_q, level_d;
    logic [8:0][7:0] cnt_q, cnt_d;

    // The level flips on the edge where the input has disagreed with it for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 9; i++) begin
            if (btn_s[i] != level_q[i]) begin
                if (cnt_q[i] == 8'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = btn_s[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 8'd1;
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
`else
    assign level = btn_s;
`endif

    always_comb begin
        clr_mask = '0;
        if (doorOpen) begin
            case (display)
                2'd1:    clr_mask = 9'b001_001_001;
                2'd2:    clr_mask = 9'b010_010_010;
                2'd3:    clr_mask = 9'b100_100_100;
                default: clr_mask = '0;
            endcase
        end
    end

    // seen_low marks a button whose real (post-reset) synchronised value has
    // been low at least once; a button held through reset cannot latch until
    // it has been released. valid_q[1] says sync2 holds a real sample rather
    // than its reset value.
    always_comb begin
        sync1_d    = {d_btn, u_btn, f_btn};
        sync2_d    = sync1_q;
        valid_d    = {valid_q[0], 1'b1};
        prev_d     = level;
        seen_low_d = seen_low_q | ({9{valid_q[1]}} & ~btn_s & REAL_MASK);
        rise       = level & ~prev_q & seen_low_q;
        // Service clear wins over a simultaneous press; the press is dropped.
        pend_d     = (pend_q | rise) & ~clr_mask & REAL_MASK;
        new_call_d = |(pend_d & ~pend_q);
        req_any_d  = |pend_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            valid_q    <= '0;
            prev_q     <= '0;
            seen_low_q <= '0;
            pend_q     <= '0;
            req_any_q  <= 1'b0;
            new_call_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            valid_q    <= valid_d;
            prev_q     <= prev_d;
            seen_low_q <= seen_low_d;
            pend_q     <= pend_d;
            req_any_q  <= req_any_d;
            new_call_q <= new_call_d;
        end
    end

    assign reg_f    = pend_q[2:0];
    assign reg_u    = pend_q[5:3];
    assign reg_d    = pend_q[8:6];
    assign req_any  = req_any_q;
    assign new_call = new_call_q;

endmodule

// File: tb/tb_call_request_latch.sv
// ---------------------------------------------------------------------------
// tb_call_request_latch
//
// Drives call_request_latch with directed scenarios and random button /
// service traffic. A behavioural model tracks the sampled button history per
// button and decides filtered levels from a sliding window of samples.
// Honours CALL_DEBOUNCE_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_call_request_latch;

  localparam int D = 4;
`ifdef CALL_DEBOUNCE_EN
  localparam int LAT = 3 + D;
`else
  localparam int LAT = 3;
`endif
  // Buttons that physically exist: f1..f3, u1..u2, d2..d3.
  localparam logic [8:0] EXISTS = 9'b110_011_111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] f_btn, u_btn, d_btn;
  logic [1:0] display;
  logic       doorOpen;
  logic [2:0] reg_f, reg_u, reg_d;
  logic       req_any, new_call;

  call_request_latch #(.DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .f_btn    (f_btn),
    .u_btn    (u_btn),
    .d_btn    (d_btn),
    .display  (display),
    .doorOpen (doorOpen),
    .reg_f    (reg_f),
    .reg_u    (reg_u),
    .reg_d    (reg_d),
    .req_any  (req_any),
    .new_call (new_call)
  );

  // ---------------- scoreboard counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-button bit index b: floor = b%3 + 1; [2:0] cabin, [5:3] up, [8:6] down.
  logic [8:0] m_s1;       // value captured by first sync stage
  logic [8:0] m_y;        // synchronised value
  logic [8:0] m_lvl;      // filtered level (debounced build)
  logic [8:0] m_lprev;    // filtered level seen at the previous edge
  logic [8:0] m_blocked;  // no real low sample seen since reset
  logic [8:0] m_pend;
  logic       m_nc, m_any;
  int         m_real;     // edges since reset
  logic [8:0] yhist[$];   // last D synchronised samples

  task automatic model_edge();
    logic [8:0] y_cur, l_cur, new_pend;
    bit all_diff;
    if (rst) begin
      m_s1 = '0; m_y = '0; m_lvl = '0; m_lprev = '0; m_pend = '0;
      m_blocked = '1; m_nc = 1'b0; m_any = 1'b0; m_real = 0;
      yhist.delete();
      return;
    end
    m_real++;
    y_cur = m_y;
`ifdef CALL_DEBOUNCE_EN
    l_cur = m_lvl;
`else
    l_cur = y_cur;
`endif
    yhist.push_back(y_cur);
    if (yhist.size() > D) void'(yhist.pop_front());
    new_pend = m_pend;
    for (int b = 0; b < 9; b++) begin
      if (l_cur[b] && !m_lprev[b] && !m_blocked[b]) new_pend[b] = 1'b1;
      if (doorOpen && (int'(display) == (b % 3) + 1)) new_pend[b] = 1'b0;
    end
    m_nc   = |(new_pend & ~m_pend);
    m_pend = new_pend;
    m_any  = |m_pend;
    if (m_real >= 3)
      for (int b = 0; b < 9; b++) if (!y_cur[b]) m_blocked[b] = 1'b0;
`ifdef CALL_DEBOUNCE_EN
    if (yhist.size() == D) begin
      for (int b = 0; b < 9; b++) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (yhist[k][b] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) m_lvl[b] = ~m_lvl[b];
      end
    end
`endif
    m_lprev = l_cur;
    m_y  = m_s1 & EXISTS;
    m_s1 = {d_btn, u_btn, f_btn};
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model consumes the inputs the DUT samples at this edge,
  // then outputs are compared 1 time unit after the edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("reg_f",    32'(reg_f),    32'(m_pend[2:0]));
    check("reg_u",    32'(reg_u),    32'(m_pend[5:3]));
    check("reg_d",    32'(reg_d),    32'(m_pend[8:6]));
    check("req_any",  32'(req_any),  32'(m_any));
    check("new_call", 32'(new_call), 32'(m_nc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; f_btn = '0; u_btn = '0; d_btn = '0; display = '0; doorOpen = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(5);
  endtask

  int nc_cnt;
  int n;
  bit found;

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; f_btn = '0; u_btn = '0; d_btn = '0; display = '0; doorOpen = 1'b0;

    // Reset state
    idle(2);
    check("rst_reg_f", 32'(reg_f), 0);
    check("rst_reg_u", 32'(reg_u), 0);
    check("rst_reg_d", 32'(reg_d), 0);
    check("rst_any",   32'(req_any), 0);
    check("rst_nc",    32'(new_call), 0);
    rst = 1'b0;
    idle(5);

    // Press latency and single new_call pulse
    f_btn = 3'b010;
    n = 0; found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(); n++;
      if (reg_f == 3'b010) found = 1;
    end
    check("press_latency", 32'(n), 32'(LAT));
    check("press_nc", 32'(new_call), 1);
    check("press_any", 32'(req_any), 1);
    step();
    check("press_nc_once", 32'(new_call), 0);
    idle(5);
    check("held_no_repeat", 32'(reg_f), 32'(3'b010));

    // Glitch rejection / short pulse
    do_reset();
`ifdef CALL_DEBOUNCE_EN
    nc_cnt = 0;
    u_btn = 3'b001;
    for (int i = 0; i < 3; i++) begin step(); nc_cnt += int'(new_call); end
    u_btn = 3'b000;
    for (int i = 0; i < 12; i++) begin step(); nc_cnt += int'(new_call); end
    check("glitch_reg_u", 32'(reg_u), 0);
    check("glitch_nc", 32'(nc_cnt), 0);
    u_btn = 3'b001;
    idle(4);
    u_btn = 3'b000;
    idle(10);
    check("pulse_reg_u", 32'(reg_u), 32'(3'b001));
`else
    u_btn = 3'b001;
    step();
    u_btn = 3'b000;
    idle(6);
    check("pulse_reg_u", 32'(reg_u), 32'(3'b001));
`endif

    // Service clear
    do_reset();
    f_btn = 3'b001; u_btn = 3'b010; d_btn = 3'b010;
    idle(LAT + 2);
    f_btn = '0; u_btn = '0; d_btn = '0;
    idle(LAT + 2);
    check("svc_set_u", 32'(reg_u), 32'(3'b010));
    check("svc_set_d", 32'(reg_d), 32'(3'b010));
    display = 2'd2; doorOpen = 1'b0;
    idle(3);
    check("svc_closed_u", 32'(reg_u), 32'(3'b010));
    check("svc_closed_d", 32'(reg_d), 32'(3'b010));
    doorOpen = 1'b1;
    step();
    check("svc_clr_u", 32'(reg_u), 0);
    check("svc_clr_d", 32'(reg_d), 0);
    check("svc_keep_f", 32'(reg_f), 32'(3'b001));
    doorOpen = 1'b0; display = 2'd0;
    idle(2);

    // Nonexistent buttons
    do_reset();
    nc_cnt = 0;
    d_btn = 3'b001; u_btn = 3'b100;
    for (int i = 0; i < 20; i++) begin step(); nc_cnt += int'(new_call); end
    check("phantom_d", 32'(reg_d), 0);
    check("phantom_u", 32'(reg_u), 0);
    check("phantom_nc", 32'(nc_cnt), 0);
    d_btn = '0; u_btn = '0;

    // Press while the floor is being served
    do_reset();
    display = 2'd3; doorOpen = 1'b1;
    nc_cnt = 0;
    f_btn = 3'b100;
    for (int i = 0; i < LAT + 5; i++) begin step(); nc_cnt += int'(new_call); end
    check("served_f3", 32'(reg_f), 0);
    check("served_nc", 32'(nc_cnt), 0);
    f_btn = 3'b000;
    idle(LAT + 3);
    nc_cnt = 0;
    f_btn = 3'b101;
    for (int i = 0; i < LAT + 5; i++) begin step(); nc_cnt += int'(new_call); end
    check("served_mix_f", 32'(reg_f), 32'(3'b001));
    check("served_mix_nc", 32'(nc_cnt), 1);
    f_btn = '0; display = 2'd0; doorOpen = 1'b0;
    idle(LAT + 3);

    // Button held through reset
    do_reset();
    f_btn = 3'b100;
    idle(LAT + 3);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    nc_cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); nc_cnt += int'(new_call); end
    check("hold_rst_f", 32'(reg_f), 0);
    check("hold_rst_any", 32'(req_any), 0);
    check("hold_rst_nc", 32'(nc_cnt), 0);
    f_btn = 3'b000;
    idle(LAT + 3);
    f_btn = 3'b100;
    idle(LAT + 2);
    check("repress_f", 32'(reg_f), 32'(3'b100));
    f_btn = 3'b000;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      for (int b = 0; b < 3; b++) begin
        if ($urandom_range(0, 5) == 0) f_btn[b] = ~f_btn[b];
        if ($urandom_range(0, 5) == 0) u_btn[b] = ~u_btn[b];
        if ($urandom_range(0, 5) == 0) d_btn[b] = ~d_btn[b];
      end
      if ($urandom_range(0, 9) == 0) display = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) doorOpen = ~doorOpen;
      step();
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
